// File: rtl/bpd_pkg.sv
// Shared types and constants for the branch-predictor update return path.
package bpd_pkg;

  localparam int unsigned FETCH_WIDTH  = 4;
  localparam int unsigned VADDR_BITS   = 40;
  localparam int unsigned META_BITS    = 120;
  localparam int unsigned CFI_IDX_BITS = $clog2(FETCH_WIDTH);

  // One parked predictor response.
  typedef struct packed {
    logic [VADDR_BITS-1:0]  pc;
    logic [FETCH_WIDTH-1:0] taken;
    logic [META_BITS-1:0]   meta;
    logic                   lhist;
  } bpd_entry_t;

  // Update message sent to the BPU.
  typedef struct packed {
    logic [VADDR_BITS-1:0]   pc;
    logic [FETCH_WIDTH-1:0]  br_mask;
    logic [FETCH_WIDTH-1:0]  taken_mask;
    logic                    cfi_valid;
    logic [CFI_IDX_BITS-1:0] cfi_idx;
    logic [VADDR_BITS-1:0]   target;
    logic                    mispredict;
    logic [FETCH_WIDTH-1:0]  dir_wrong;
    logic [META_BITS-1:0]    meta;
    logic                    lhist;
  } bpd_update_t;

  // Index of the lowest set bit, 0 when no bit is set.
  function automatic logic [CFI_IDX_BITS-1:0] lowest_set(input logic [FETCH_WIDTH-1:0] mask);
    logic [CFI_IDX_BITS-1:0] idx;
    idx = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (mask[i]) idx = CFI_IDX_BITS'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bpd_entry_ring.sv
// In-order ring of parked predictor responses with its pointers and occupancy count.
module bpd_entry_ring
  import bpd_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  localparam int unsigned IDXW   = $clog2(ENTRIES)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enq,
  input  bpd_entry_t      enq_data,
  input  logic            deq,
  output bpd_entry_t      deq_data,
  output logic [IDXW-1:0] enq_ptr,
  output logic [IDXW-1:0] deq_ptr,
  output logic [IDXW:0]   count
);

  bpd_entry_t      mem_q [ENTRIES];
  logic [IDXW-1:0] enq_ptr_q, enq_ptr_d;
  logic [IDXW-1:0] deq_ptr_q, deq_ptr_d;
  logic [IDXW:0]   count_q, count_d;

  // Next pointers wrap naturally since ENTRIES is a power of two.
  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (enq) enq_ptr_d = enq_ptr_q + 1'b1;
    if (deq) deq_ptr_d = deq_ptr_q + 1'b1;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state.
  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage write port; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (enq) mem_q[enq_ptr_q] <= enq_data;
  end

  assign deq_data = mem_q[deq_ptr_q];
  assign enq_ptr  = enq_ptr_q;
  assign deq_ptr  = deq_ptr_q;
  assign count    = count_q;

endmodule

// File: rtl/bpd_update_gen.sv
// Parks predictor responses and turns in-order commits into registered BPU update messages.
module bpd_update_gen
  import bpd_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  localparam int unsigned IDXW   = $clog2(ENTRIES)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_resp_valid,
  output logic                    io_resp_ready,
  input  logic [VADDR_BITS-1:0]   io_resp_bits_pc,
  input  logic [FETCH_WIDTH-1:0]  io_resp_bits_preds_taken,
  input  logic [META_BITS-1:0]    io_resp_bits_meta_0,
  input  logic                    io_resp_bits_lhist_0,
  output logic [IDXW-1:0]         io_resp_idx,
  input  logic                    io_commit_valid,
  output logic                    io_commit_ready,
  input  logic [IDXW-1:0]         io_commit_idx,
  input  logic [FETCH_WIDTH-1:0]  io_commit_br_mask,
  input  logic [FETCH_WIDTH-1:0]  io_commit_taken_mask,
  input  logic [VADDR_BITS-1:0]   io_commit_target,
  input  logic                    io_commit_mispredict,
  output logic                    io_update_valid,
  input  logic                    io_update_ready,
  output logic [VADDR_BITS-1:0]   io_update_bits_pc,
  output logic [FETCH_WIDTH-1:0]  io_update_bits_br_mask,
  output logic [FETCH_WIDTH-1:0]  io_update_bits_taken_mask,
  output logic                    io_update_bits_cfi_valid,
  output logic [CFI_IDX_BITS-1:0] io_update_bits_cfi_idx,
  output logic [VADDR_BITS-1:0]   io_update_bits_target,
  output logic                    io_update_bits_mispredict,
  output logic [FETCH_WIDTH-1:0]  io_update_bits_dir_wrong,
  output logic [META_BITS-1:0]    io_update_bits_meta_0,
  output logic                    io_update_bits_lhist_0
);

  localparam logic [IDXW:0] FullCount = (IDXW + 1)'(ENTRIES);

  bpd_entry_t      enq_data, head;
  logic [IDXW-1:0] enq_ptr, deq_ptr;
  logic [IDXW:0]   count;
  logic            enq_fire, commit_fire;
  logic            upd_valid_q, upd_valid_d;
  bpd_update_t     upd_q, upd_d;

  assign enq_data = '{pc:    io_resp_bits_pc,
                      taken: io_resp_bits_preds_taken,
                      meta:  io_resp_bits_meta_0,
                      lhist: io_resp_bits_lhist_0};

  // Ready comes from the registered count, so a full ring stays closed during a commit.
  assign io_resp_ready   = (count != FullCount);
  assign enq_fire        = io_resp_valid & io_resp_ready;
  // Out-of-order indices are stalled, never dropped.
  assign io_commit_ready = (count != '0) & (io_commit_idx == deq_ptr) &
                           (~upd_valid_q | io_update_ready);
  assign commit_fire     = io_commit_valid & io_commit_ready;
  assign io_resp_idx     = enq_ptr;

  bpd_entry_ring #(
    .ENTRIES (ENTRIES)
  ) u_ring (
    .clock    (clock),
    .reset    (reset),
    .enq      (enq_fire),
    .enq_data (enq_data),
    .deq      (commit_fire),
    .deq_data (head),
    .enq_ptr  (enq_ptr),
    .deq_ptr  (deq_ptr),
    .count    (count)
  );

  // Merge the ring head with the resolved outcome; a commit during acceptance reloads seamlessly.
  always_comb begin
    upd_d       = upd_q;
    upd_valid_d = upd_valid_q;
    if (commit_fire) begin
      upd_valid_d      = 1'b1;
      upd_d.pc         = head.pc;
      upd_d.br_mask    = io_commit_br_mask;
      upd_d.taken_mask = io_commit_taken_mask;
      upd_d.cfi_valid  = |io_commit_taken_mask;
      upd_d.cfi_idx    = lowest_set(io_commit_taken_mask);
      upd_d.target     = io_commit_target;
      upd_d.mispredict = io_commit_mispredict;
      upd_d.dir_wrong  = (head.taken ^ io_commit_taken_mask) & io_commit_br_mask;
      upd_d.meta       = head.meta;
      upd_d.lhist      = head.lhist;
    end else if (io_update_ready) begin
      upd_valid_d = 1'b0;
    end
  end

  // Update output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      upd_valid_q <= 1'b0;
      upd_q       <= '0;
    end else begin
      upd_valid_q <= upd_valid_d;
      upd_q       <= upd_d;
    end
  end

  assign io_update_valid           = upd_valid_q;
  assign io_update_bits_pc         = upd_q.pc;
  assign io_update_bits_br_mask    = upd_q.br_mask;
  assign io_update_bits_taken_mask = upd_q.taken_mask;
  assign io_update_bits_cfi_valid  = upd_q.cfi_valid;
  assign io_update_bits_cfi_idx    = upd_q.cfi_idx;
  assign io_update_bits_target     = upd_q.target;
  assign io_update_bits_mispredict = upd_q.mispredict;
  assign io_update_bits_dir_wrong  = upd_q.dir_wrong;
  assign io_update_bits_meta_0     = upd_q.meta;
  assign io_update_bits_lhist_0    = upd_q.lhist;

endmodule

// File: tb/tb_bpd_update_gen.sv
// Directed self-checking bench for bpd_update_gen.
module tb_bpd_update_gen;
  import bpd_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         io_resp_valid;
  logic         io_resp_ready;
  logic [39:0]  io_resp_bits_pc;
  logic [3:0]   io_resp_bits_preds_taken;
  logic [119:0] io_resp_bits_meta_0;
  logic         io_resp_bits_lhist_0;
  logic [1:0]   io_resp_idx;
  logic         io_commit_valid;
  logic         io_commit_ready;
  logic [1:0]   io_commit_idx;
  logic [3:0]   io_commit_br_mask;
  logic [3:0]   io_commit_taken_mask;
  logic [39:0]  io_commit_target;
  logic         io_commit_mispredict;
  logic         io_update_valid;
  logic         io_update_ready;
  logic [39:0]  io_update_bits_pc;
  logic [3:0]   io_update_bits_br_mask;
  logic [3:0]   io_update_bits_taken_mask;
  logic         io_update_bits_cfi_valid;
  logic [1:0]   io_update_bits_cfi_idx;
  logic [39:0]  io_update_bits_target;
  logic         io_update_bits_mispredict;
  logic [3:0]   io_update_bits_dir_wrong;
  logic [119:0] io_update_bits_meta_0;
  logic         io_update_bits_lhist_0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  bpd_update_gen #(.ENTRIES(4)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .io_resp_valid             (io_resp_valid),
    .io_resp_ready             (io_resp_ready),
    .io_resp_bits_pc           (io_resp_bits_pc),
    .io_resp_bits_preds_taken  (io_resp_bits_preds_taken),
    .io_resp_bits_meta_0       (io_resp_bits_meta_0),
    .io_resp_bits_lhist_0      (io_resp_bits_lhist_0),
    .io_resp_idx               (io_resp_idx),
    .io_commit_valid           (io_commit_valid),
    .io_commit_ready           (io_commit_ready),
    .io_commit_idx             (io_commit_idx),
    .io_commit_br_mask         (io_commit_br_mask),
    .io_commit_taken_mask      (io_commit_taken_mask),
    .io_commit_target          (io_commit_target),
    .io_commit_mispredict      (io_commit_mispredict),
    .io_update_valid           (io_update_valid),
    .io_update_ready           (io_update_ready),
    .io_update_bits_pc         (io_update_bits_pc),
    .io_update_bits_br_mask    (io_update_bits_br_mask),
    .io_update_bits_taken_mask (io_update_bits_taken_mask),
    .io_update_bits_cfi_valid  (io_update_bits_cfi_valid),
    .io_update_bits_cfi_idx    (io_update_bits_cfi_idx),
    .io_update_bits_target     (io_update_bits_target),
    .io_update_bits_mispredict (io_update_bits_mispredict),
    .io_update_bits_dir_wrong  (io_update_bits_dir_wrong),
    .io_update_bits_meta_0     (io_update_bits_meta_0),
    .io_update_bits_lhist_0    (io_update_bits_lhist_0)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    io_resp_valid            = 1'b0;
    io_resp_bits_pc          = '0;
    io_resp_bits_preds_taken = '0;
    io_resp_bits_meta_0      = '0;
    io_resp_bits_lhist_0     = 1'b0;
    io_commit_valid          = 1'b0;
    io_commit_idx            = '0;
    io_commit_br_mask        = '0;
    io_commit_taken_mask     = '0;
    io_commit_target         = '0;
    io_commit_mispredict     = 1'b0;
    io_update_ready          = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic enq(input logic [39:0] pc, input logic [3:0] tk, input logic [119:0] meta,
                     input logic lh);
    io_resp_valid            = 1'b1;
    io_resp_bits_pc          = pc;
    io_resp_bits_preds_taken = tk;
    io_resp_bits_meta_0      = meta;
    io_resp_bits_lhist_0     = lh;
  endtask

  task automatic commit(input logic [1:0] idx, input logic [3:0] br, input logic [3:0] tk,
                        input logic [39:0] tgt, input logic mp);
    io_commit_valid      = 1'b1;
    io_commit_idx        = idx;
    io_commit_br_mask    = br;
    io_commit_taken_mask = tk;
    io_commit_target     = tgt;
    io_commit_mispredict = mp;
  endtask

  initial begin
    reset = 1'b1;
    do_reset();

    // Reset state
    chk("rst_resp_ready", io_resp_ready, 1);
    chk("rst_commit_ready", io_commit_ready, 0);
    chk("rst_resp_idx", io_resp_idx, 0);
    chk("rst_update_valid", io_update_valid, 0);
    chk("rst_update_pc", io_update_bits_pc, 0);
    chk("rst_update_meta", io_update_bits_meta_0, 0);

    // Basic enqueue then commit
    enq(40'h80_0000_0000 >> 8, 4'b0010, 120'hABC, 1'b1);
    #1;
    chk("t1_resp_idx", io_resp_idx, 0);
    tick();
    io_resp_valid = 1'b0;
    commit(2'd0, 4'b0011, 4'b0001, 40'h00_8000_0010, 1'b1);
    #1;
    chk("t1_commit_ready", io_commit_ready, 1);
    tick();
    io_commit_valid = 1'b0;
    chk("t1_upd_valid", io_update_valid, 1);
    chk("t1_upd_pc", io_update_bits_pc, 40'h00_8000_0000);
    chk("t1_upd_cfi_valid", io_update_bits_cfi_valid, 1);
    chk("t1_upd_cfi_idx", io_update_bits_cfi_idx, 0);
    chk("t1_upd_dir_wrong", io_update_bits_dir_wrong, 4'b0011);
    chk("t1_upd_meta", io_update_bits_meta_0, 120'hABC);
    chk("t1_upd_lhist", io_update_bits_lhist_0, 1);
    chk("t1_upd_target", io_update_bits_target, 40'h00_8000_0010);
    chk("t1_upd_br_mask", io_update_bits_br_mask, 4'b0011);
    chk("t1_upd_taken_mask", io_update_bits_taken_mask, 4'b0001);
    chk("t1_upd_mispredict", io_update_bits_mispredict, 1);
    io_update_ready = 1'b1;
    tick();
    chk("t1_upd_cleared", io_update_valid, 0);

    // Fill, full boundary, wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      enq(40'h1000 + 40'(i * 16), 4'(i), 120'(i + 1), 1'b0);
      #1;
      chk("t2_fill_idx", io_resp_idx, 128'(i));
      chk("t2_fill_ready", io_resp_ready, 1);
      tick();
    end
    io_resp_valid = 1'b0;
    #1;
    chk("t2_full_ready", io_resp_ready, 0);
    enq(40'h3000, 4'b0000, 120'h9, 1'b0);
    commit(2'd0, 4'b1111, 4'b0000, 40'h0, 1'b0);
    io_update_ready = 1'b1;
    #1;
    chk("t2_commit_ready", io_commit_ready, 1);
    chk("t2_full_during_commit", io_resp_ready, 0);
    tick();
    io_commit_valid = 1'b0;
    io_resp_valid   = 1'b0;
    chk("t2_reopen", io_resp_ready, 1);
    chk("t2_upd_pc", io_update_bits_pc, 40'h1000);
    chk("t2_upd_cfi_valid", io_update_bits_cfi_valid, 0);
    chk("t2_upd_dir_wrong", io_update_bits_dir_wrong, 4'b0000);
    enq(40'h2000, 4'b1111, 120'h5, 1'b0);
    #1;
    chk("t2_wrap_idx", io_resp_idx, 0);
    tick();
    io_resp_valid = 1'b0;
    chk("t2_upd_drained", io_update_valid, 0);
    chk("t2_full_again", io_resp_ready, 0);

    // Out-of-order index held off
    do_reset();
    enq(40'hA0, 4'b0001, 120'h1, 1'b0);
    tick();
    enq(40'hA1, 4'b0000, 120'h2, 1'b1);
    tick();
    io_resp_valid = 1'b0;
    commit(2'd1, 4'b0001, 4'b0001, 40'h44, 1'b0);
    #1;
    chk("t3_wrong_idx_ready", io_commit_ready, 0);
    tick();
    chk("t3_no_dequeue", io_update_valid, 0);
    io_commit_idx = 2'd0;
    #1;
    chk("t3_right_idx_ready", io_commit_ready, 1);
    tick();
    io_commit_valid = 1'b0;
    chk("t3_upd_valid", io_update_valid, 1);
    chk("t3_upd_pc", io_update_bits_pc, 40'hA0);
    chk("t3_upd_dir_wrong", io_update_bits_dir_wrong, 4'b0000);

    // Update backpressure, then back-to-back reload
    io_update_ready = 1'b0;
    commit(2'd1, 4'b0011, 4'b0010, 40'h55, 1'b1);
    #1;
    chk("t4_bp_commit_ready", io_commit_ready, 0);
    tick();
    chk("t4_bp_valid_held", io_update_valid, 1);
    chk("t4_bp_pc_held", io_update_bits_pc, 40'hA0);
    chk("t4_bp_target_held", io_update_bits_target, 40'h44);
    io_update_ready = 1'b1;
    #1;
    chk("t4_release_ready", io_commit_ready, 1);
    tick();
    io_commit_valid = 1'b0;
    chk("t4_b2b_valid", io_update_valid, 1);
    chk("t4_b2b_pc", io_update_bits_pc, 40'hA1);
    chk("t4_b2b_lhist", io_update_bits_lhist_0, 1);
    chk("t4_b2b_cfi_idx", io_update_bits_cfi_idx, 1);
    chk("t4_b2b_dir_wrong", io_update_bits_dir_wrong, 4'b0010);
    tick();
    chk("t4_drained", io_update_valid, 0);
    chk("t4_empty_ready", io_commit_ready, 0);

    // No-taken commit with simultaneous enqueue, then lowest-set selection
    do_reset();
    enq(40'hB0, 4'b0000, 120'h7, 1'b0);
    tick();
    enq(40'hB1, 4'b1000, 120'h8, 1'b0);
    commit(2'd0, 4'b0001, 4'b0000, 40'h0, 1'b0);
    io_update_ready = 1'b1;
    #1;
    chk("t5_sim_commit_ready", io_commit_ready, 1);
    tick();
    io_resp_valid = 1'b0;
    io_commit_valid = 1'b0;
    chk("t5_cfi_valid", io_update_bits_cfi_valid, 0);
    chk("t5_cfi_idx", io_update_bits_cfi_idx, 0);
    chk("t5_pc", io_update_bits_pc, 40'hB0);
    commit(2'd1, 4'b1111, 4'b0110, 40'h66, 1'b0);
    #1;
    chk("t5_count_kept", io_commit_ready, 1);
    tick();
    chk("t5_cfi_idx_multi", io_update_bits_cfi_idx, 1);
    chk("t5_cfi_valid_multi", io_update_bits_cfi_valid, 1);
    chk("t5_dir_wrong_multi", io_update_bits_dir_wrong, 4'b1110);
    io_commit_idx = 2'd2;
    #1;
    chk("t5_empty_blocks", io_commit_ready, 0);
    io_commit_valid = 1'b0;

    // Reset with entries and a pending update
    do_reset();
    for (int i = 0; i < 3; i++) begin
      enq(40'hC0 + 40'(i), 4'b0000, 120'h0, 1'b0);
      tick();
    end
    io_resp_valid = 1'b0;
    commit(2'd0, 4'b0000, 4'b0001, 40'h77, 1'b0);
    tick();
    io_commit_valid = 1'b0;
    chk("t6_pending", io_update_valid, 1);
    reset = 1'b1;
    tick();
    chk("t6_rst_upd_valid", io_update_valid, 0);
    chk("t6_rst_resp_ready", io_resp_ready, 1);
    chk("t6_rst_resp_idx", io_resp_idx, 0);
    chk("t6_rst_upd_pc", io_update_bits_pc, 0);
    reset = 1'b0;
    io_commit_valid = 1'b1;
    io_commit_idx   = 2'd1;
    #1;
    chk("t6_rst_commit_ready", io_commit_ready, 0);
    io_commit_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
